// File: rtl/apu_frame_counter.sv
// apu_frame_counter: NES APU frame sequencer with quarter/half-frame pulses,
// $4017 mode/inhibit control, delayed sequencer reset and frame IRQ flag.
`default_nettype none

module apu_frame_counter #(
    parameter int STEP1 = 7457,
    parameter int STEP2 = 14913,
    parameter int STEP3 = 22371,
    parameter int STEP4 = 29829,
    parameter int STEP5 = 37281,
    parameter int CW    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       wr,
    input  logic [1:0] wdata,
    input  logic       irq_ack,
    output logic       quarter_frame,
    output logic       half_frame,
    output logic       irq,
    output logic       mode
);

    localparam logic [CW-1:0] S1   = CW'(STEP1);
    localparam logic [CW-1:0] S2   = CW'(STEP2);
    localparam logic [CW-1:0] S3   = CW'(STEP3);
    localparam logic [CW-1:0] S4   = CW'(STEP4);
    localparam logic [CW-1:0] S4M1 = CW'(STEP4 - 1);
    localparam logic [CW-1:0] S4P1 = CW'(STEP4 + 1);
    localparam logic [CW-1:0] S5   = CW'(STEP5);
    localparam logic [CW-1:0] S5P1 = CW'(STEP5 + 1);

    logic [CW-1:0] cyc;
    logic          parity;
    logic          inhibit;
    logic          pend;
    logic [2:0]    pend_cnt;

    logic step_q;
    logic step_h;
    logic irq_window;
    logic wrap;
    logic fire;
    logic inhibit_eff;
    logic irq_set;

    // Step decode on the pre-increment count, using the currently latched mode.
    always_comb begin
        step_q     = 1'b0;
        step_h     = 1'b0;
        irq_window = 1'b0;
        wrap       = 1'b0;
        if (cyc == S1 || cyc == S2 || cyc == S3)
            step_q = 1'b1;
        if (cyc == S2)
            step_h = 1'b1;
        if (!mode) begin
            if (cyc == S4) begin
                step_q = 1'b1;
                step_h = 1'b1;
            end
            if (cyc == S4M1 || cyc == S4 || cyc == S4P1)
                irq_window = 1'b1;
            if (cyc == S4P1)
                wrap = 1'b1;
        end else begin
            if (cyc == S5) begin
                step_q = 1'b1;
                step_h = 1'b1;
            end
            if (cyc == S5P1)
                wrap = 1'b1;
        end
    end

    // A fresh write on the firing clock reloads the delay instead of firing.
    assign fire        = en && pend && (pend_cnt == 3'd1) && !wr;
    assign inhibit_eff = wr ? wdata[0] : inhibit;
    assign irq_set     = en && !fire && irq_window && !inhibit_eff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc           <= '0;
            parity        <= 1'b0;
            mode          <= 1'b0;
            inhibit       <= 1'b0;
            irq           <= 1'b0;
            quarter_frame <= 1'b0;
            half_frame    <= 1'b0;
            pend          <= 1'b0;
            pend_cnt      <= 3'd0;
        end else begin
            quarter_frame <= 1'b0;
            half_frame    <= 1'b0;

            if (wr) begin
                mode     <= wdata[1];
                inhibit  <= wdata[0];
                pend     <= 1'b1;
                pend_cnt <= parity ? 3'd4 : 3'd3;
            end

            if (en) begin
                parity <= ~parity;
                if (fire) begin
                    cyc           <= '0;
                    pend          <= 1'b0;
                    pend_cnt      <= 3'd0;
                    quarter_frame <= mode;
                    half_frame    <= mode;
                end else begin
                    cyc           <= wrap ? '0 : cyc + CW'(1);
                    quarter_frame <= step_q;
                    half_frame    <= step_h;
                    if (pend && !wr)
                        pend_cnt <= pend_cnt - 3'd1;
                end
            end

            if (irq_set)
                irq <= 1'b1;
            else if (irq_ack || (wr && wdata[0]))
                irq <= 1'b0;
        end
    end

endmodule

`default_nettype wire
